recovery_checkpoint_ctrl: RTL and testbench

Checkpoint/restore sequencer placed directly upstream of the recovery register file in the TMR RISC-V core. On a checkpoint request, it copies the voted architectural register file and PC into the recovery register file, one register per cycle. On a fault request from the TMR voter, it walks the recovery register file and writes every register back into the replicated core register files, then reloads the checkpointed PC. While either sequence runs, it stalls the cores.

---
 rtl/riscv_tmr_pkg.sv | 16 +
 rtl/recovery_checkpoint_ctrl.sv | 131 +++++++++++++
 tb/tb_recovery_checkpoint_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_tmr_pkg.sv
// Shared parameters and types for the TMR RISC-V core recovery logic.
package riscv_tmr_pkg;

    localparam int XLEN        = 32;
    localparam int NREGS       = 32;
    localparam int AW          = 5;
    localparam int FAULT_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAVE    = 2'd1,
        RESTORE = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/recovery_checkpoint_ctrl.sv
// Checkpoint/restore sequencer between the voted core register file and the
// recovery register file; stalls the cores while copying in either direction.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | cores run, waiting for ckpt_req / fault_req
// SAVE    | copy voted RF[idx] into recovery RF, one register per cycle
// RESTORE | copy recovery RF[idx] into all core RFs, idx 1..NREGS-1
// DONE    | one-cycle done pulse (plus pc_load after a restore)
module recovery_checkpoint_ctrl
    import riscv_tmr_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_in,
    input  logic                   ckpt_req,
    input  logic                   fault_req,
    input  logic [XLEN-1:0]        pc_in,
    output logic [AW-1:0]          rf_raddr,
    input  logic [XLEN-1:0]        rf_rdata,
    output logic                   rf_we,
    output logic [AW-1:0]          rf_waddr,
    output logic [XLEN-1:0]        rf_wdata,
    output logic                   rec_we,
    output logic [XLEN-1:0]        rec_a,
    output logic [XLEN-1:0]        rec_wd,
    input  logic [XLEN-1:0]        rec_rd,
    output logic                   stall_out,
    output logic                   done,
    output logic                   pc_load,
    output logic [XLEN-1:0]        pc_restore,
    output logic [FAULT_CNT_W-1:0] fault_count
);

    state_t                 state, state_nxt;
    logic [AW-1:0]          idx, idx_nxt;
    logic                   pending, pending_nxt;
    logic                   restoring, restoring_nxt;
    logic [XLEN-1:0]        pc_q, pc_nxt;
    logic [FAULT_CNT_W-1:0] fcnt, fcnt_nxt;
    logic [FAULT_CNT_W-1:0] fcnt_sat;
    logic                   last_idx;

    assign last_idx = (idx == AW'(NREGS - 1));
    assign fcnt_sat = (fcnt == {FAULT_CNT_W{1'b1}}) ? fcnt : fcnt + FAULT_CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state     <= IDLE;
            idx       <= '0;
            pending   <= 1'b0;
            restoring <= 1'b0;
            pc_q      <= '0;
            fcnt      <= '0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            pending   <= pending_nxt;
            restoring <= restoring_nxt;
            pc_q      <= pc_nxt;
            fcnt      <= fcnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        pending_nxt   = pending;
        restoring_nxt = restoring;
        pc_nxt        = pc_q;
        fcnt_nxt      = fcnt;
        rec_we        = 1'b0;
        rec_wd        = '0;
        rf_we         = 1'b0;
        rf_wdata      = '0;
        done          = 1'b0;
        pc_load       = 1'b0;

        case (state)
            IDLE: begin
                if (fault_req) begin
                    state_nxt     = RESTORE;
                    idx_nxt       = AW'(1);
                    restoring_nxt = 1'b1;
                    fcnt_nxt      = fcnt_sat;
                end else if (ckpt_req) begin
                    state_nxt     = SAVE;
                    idx_nxt       = '0;
                    restoring_nxt = 1'b0;
                    pc_nxt        = pc_in;
                end
            end
            SAVE: begin
                pending_nxt = pending | fault_req;
                rec_we      = 1'b1;
                rec_wd      = rf_rdata;
                if (last_idx) state_nxt = DONE;
                else          idx_nxt   = idx + AW'(1);
            end
            RESTORE: begin
                pending_nxt = pending | fault_req;
                rf_we       = 1'b1;
                rf_wdata    = rec_rd;
                if (last_idx) state_nxt = DONE;
                else          idx_nxt   = idx + AW'(1);
            end
            DONE: begin
                done    = 1'b1;
                pc_load = restoring;
                // A fault arriving in DONE itself is folded into the pending restore.
                if (pending || fault_req) begin
                    state_nxt     = RESTORE;
                    idx_nxt       = AW'(1);
                    pending_nxt   = 1'b0;
                    restoring_nxt = 1'b1;
                    fcnt_nxt      = fcnt_sat;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rf_raddr    = idx;
    assign rf_waddr    = idx;
    assign rec_a       = XLEN'(idx);
    assign stall_out   = (state != IDLE);
    assign pc_restore  = pc_q;
    assign fault_count = fcnt;

endmodule

// File: tb/tb_recovery_checkpoint_ctrl.sv
// Bench for recovery_checkpoint_ctrl: table vectors, random request pairs,
// fault counter saturation and reset mid-restore.
module tb_recovery_checkpoint_ctrl;
    import riscv_tmr_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst_in, ckpt_req, fault_req;
    logic [XLEN-1:0]        pc_in, rf_rdata, rf_wdata, rec_a, rec_wd, rec_rd, pc_restore;
    logic [AW-1:0]          rf_raddr, rf_waddr;
    logic                   rf_we, rec_we, stall_out, done, pc_load;
    logic [FAULT_CNT_W-1:0] fault_count;

    recovery_checkpoint_ctrl dut (
        .clk(clk), .rst_in(rst_in), .ckpt_req(ckpt_req), .fault_req(fault_req),
        .pc_in(pc_in), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rec_we(rec_we), .rec_a(rec_a),
        .rec_wd(rec_wd), .rec_rd(rec_rd), .stall_out(stall_out), .done(done),
        .pc_load(pc_load), .pc_restore(pc_restore), .fault_count(fault_count)
    );

    always #5 clk = ~clk;

    // Register file models around the DUT
    logic [XLEN-1:0] main_rf [NREGS];
    logic [XLEN-1:0] rec_rf  [NREGS];
    logic [XLEN-1:0] core_rf [NREGS];
    logic [XLEN-1:0] exp_rec [NREGS];
    logic [XLEN-1:0] exp_core[NREGS];
    logic            tb_init = 1'b1;

    assign rf_rdata = main_rf[rf_raddr];
    assign rec_rd   = rec_rf[rec_a[AW-1:0]];

    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < NREGS; i++) begin
                rec_rf[i]  <= '0;
                core_rf[i] <= 32'hDEAD_0000 + i;
            end
        end else begin
            if (rec_we) rec_rf[rec_a[AW-1:0]] <= rec_wd;
            if (rf_we)  core_rf[rf_waddr]     <= rf_wdata;
        end
    end

    typedef struct {
        bit c0; bit f0;          // first request
        bit c1; bit f1; int at;  // second request at active cycle 'at' (-1 none)
        int n_rec; int n_rf; int n_done; int n_pcl; int stall; int first_done;
    } vec_t;

    int              tests = 0, fails = 0;
    int              bad, n_rec, n_rf, n_done, n_pcl, n_stall, first_done;
    int              fcnt_m = 0;
    logic [XLEN-1:0] pc_m = '0;
    vec_t            tbl[8];

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected sequence shape from request flags: SAVE = 32 writes + DONE,
    // RESTORE = 31 writes + DONE, a fault inside a sequence chains one restore.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        bit   s1 = !v.f0 && v.c0;
        bit   f1 = (v.at >= 0) && v.f1;
        int   span1 = s1 ? NREGS + 1 : NREGS;
        r.n_rec      = s1 ? NREGS : 0;
        r.n_rf       = (v.f0 ? NREGS - 1 : 0) + (f1 ? NREGS - 1 : 0);
        r.n_done     = 1 + int'(f1);
        r.n_pcl      = int'(v.f0) + int'(f1);
        r.stall      = span1 + (f1 ? NREGS : 0);
        r.first_done = span1 - 1;
        return r;
    endfunction

    task automatic sample(input int cyc);
        if (stall_out) n_stall++;
        if (rec_we) begin
            n_rec++;
            if (rec_wd !== main_rf[rec_a[AW-1:0]] || rec_a !== XLEN'(rf_raddr)) bad++;
        end
        if (rf_we) begin
            n_rf++;
            if (rf_waddr == 0 || rf_wdata !== rec_rf[rf_waddr] || rec_a !== XLEN'(rf_waddr)) bad++;
        end
        if (done) begin
            n_done++;
            if (first_done < 0) first_done = cyc;
        end
        if (pc_load) begin
            n_pcl++;
            if (!done || pc_restore !== pc_m) bad++;
        end
        if ((rec_we || rf_we || done) && !stall_out) bad++;
        if (rec_we && rf_we) bad++;
    endtask

    task automatic do_restore_model();
        for (int i = 1; i < NREGS; i++) exp_core[i] = exp_rec[i];
        if (fcnt_m < 255) fcnt_m++;
    endtask

    task automatic run_vec(input vec_t v, input logic [XLEN-1:0] pc, input string nm);
        bit s1 = !v.f0 && v.c0;
        bit f1 = (v.at >= 0) && v.f1;
        int cyc = 0;
        bit fin = 0;
        int m_rec = 0, m_core = 0;
        if (s1) pc_m = pc;
        bad = 0; n_rec = 0; n_rf = 0; n_done = 0; n_pcl = 0; n_stall = 0; first_done = -1;
        @(negedge clk);
        pc_in = pc; ckpt_req = v.c0; fault_req = v.f0;
        @(negedge clk);
        ckpt_req = 1'b0; fault_req = 1'b0;
        while (!fin && cyc < 300) begin
            if (cyc == v.at) begin ckpt_req = v.c1; fault_req = v.f1; end
            else begin ckpt_req = 1'b0; fault_req = 1'b0; end
            sample(cyc);
            if (!stall_out) fin = 1;
            else begin @(negedge clk); cyc++; end
        end
        ckpt_req = 1'b0; fault_req = 1'b0;
        if (s1) for (int i = 0; i < NREGS; i++) exp_rec[i] = main_rf[i];
        if (v.f0) do_restore_model();
        if (f1) do_restore_model();
        for (int i = 0; i < NREGS; i++) begin
            if (rec_rf[i] !== exp_rec[i]) m_rec++;
            if (core_rf[i] !== exp_core[i]) m_core++;
        end
        chk({nm, " finished"}, fin, 1);
        chk({nm, " rec_we cycles"}, n_rec, v.n_rec);
        chk({nm, " rf_we cycles"}, n_rf, v.n_rf);
        chk({nm, " done pulses"}, n_done, v.n_done);
        chk({nm, " pc_load pulses"}, n_pcl, v.n_pcl);
        chk({nm, " stall cycles"}, n_stall, v.stall);
        chk({nm, " first done cycle"}, first_done, v.first_done);
        chk({nm, " per-cycle errors"}, bad, 0);
        chk({nm, " recovery rf mismatches"}, m_rec, 0);
        chk({nm, " core rf mismatches"}, m_core, 0);
        chk({nm, " pc_restore"}, pc_restore, pc_m);
        chk({nm, " fault_count"}, fault_count, fcnt_m);
    endtask

    initial begin
        vec_t rv;
        int   fin;
        rst_in = 1'b1; ckpt_req = 1'b0; fault_req = 1'b0; pc_in = '0;
        for (int k = 0; k < NREGS; k++) begin
            main_rf[k]  = k * 32'h11;
            exp_rec[k]  = '0;
            exp_core[k] = 32'hDEAD_0000 + k;
        end
        repeat (3) @(negedge clk);
        tb_init = 1'b0;
        rst_in  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle stall_out", stall_out, 0);
        end
        chk("reset done", done, 0);
        chk("reset pc_load", pc_load, 0);
        chk("reset rec_we", rec_we, 0);
        chk("reset rf_we", rf_we, 0);
        chk("reset rf_raddr", rf_raddr, 0);
        chk("reset rec_a", rec_a, 0);
        chk("reset rec_wd", rec_wd, 0);
        chk("reset rf_wdata", rf_wdata, 0);
        chk("reset pc_restore", pc_restore, 0);
        chk("reset fault_count", fault_count, 0);

        //          c0 f0 c1 f1  at  rec  rf done pcl stall fdone
        tbl[0] = '{1, 0, 0, 0, -1, 32,  0, 1, 0, 33, 32};
        tbl[1] = '{0, 1, 0, 0, -1,  0, 31, 1, 1, 32, 31};
        tbl[2] = '{1, 1, 0, 0, -1,  0, 31, 1, 1, 32, 31};
        tbl[3] = '{1, 0, 0, 1, 10, 32, 31, 2, 1, 65, 32};
        tbl[4] = '{0, 1, 0, 1,  5,  0, 62, 2, 2, 64, 31};
        tbl[5] = '{0, 1, 1, 0,  5,  0, 31, 1, 1, 32, 31};
        tbl[6] = '{1, 0, 1, 0,  3, 32,  0, 1, 0, 33, 32};
        tbl[7] = '{1, 0, 1, 1, 20, 32, 31, 2, 1, 65, 32};
        for (int t = 0; t < 8; t++) begin
            if (t >= 2) for (int k = 0; k < NREGS; k++) main_rf[k] = $urandom;
            run_vec(tbl[t], (t < 2) ? 32'h80 : $urandom, $sformatf("vec%0d", t));
        end

        for (int t = 0; t < 20; t++) begin
            rv.c0 = 1'($urandom % 2);
            rv.f0 = 1'($urandom % 2);
            if (!rv.c0 && !rv.f0) rv.c0 = 1'b1;
            rv.c1 = 1'($urandom % 2);
            rv.f1 = 1'($urandom % 2);
            rv.at = ($urandom % 2) ? int'($urandom_range(0, 30)) : -1;
            for (int k = 0; k < NREGS; k++) main_rf[k] = $urandom;
            run_vec(model(rv), $urandom, $sformatf("rnd%0d", t));
        end

        for (int i = 0; i < 300; i++) begin
            @(negedge clk); fault_req = 1'b1;
            @(negedge clk); fault_req = 1'b0;
            fin = 0;
            for (int c = 0; c < 40 && !fin; c++) begin
                @(negedge clk);
                if (!stall_out) fin = 1;
            end
            if (fcnt_m < 255) fcnt_m++;
            chk("saturation run finished", fin, 1);
            chk("fault_count saturating", fault_count, fcnt_m);
        end

        @(negedge clk); fault_req = 1'b1;
        @(negedge clk); fault_req = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid-restore stall", stall_out, 1);
        chk("mid-restore rf_we", rf_we, 1);
        rst_in = 1'b1; fault_req = 1'b1;
        @(negedge clk);
        chk("after reset stall", stall_out, 0);
        chk("after reset done", done, 0);
        chk("after reset pc_load", pc_load, 0);
        chk("after reset rf_we", rf_we, 0);
        chk("after reset rf_waddr", rf_waddr, 0);
        chk("after reset fault_count", fault_count, 0);
        chk("after reset pc_restore", pc_restore, 0);
        @(negedge clk);
        chk("reset beats fault_req", stall_out, 0);
        rst_in = 1'b0; fault_req = 1'b0;
        n_done = 0; n_pcl = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) n_done++;
            if (pc_load) n_pcl++;
        end
        chk("no done after abort", n_done, 0);
        chk("no pc_load after abort", n_pcl, 0);
        chk("idle after abort", stall_out, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
